// File: rtl/axis_rr_packet_arbiter_if.sv
// Stream bundle shared by the packet sources, the round-robin arbiter and the
// downstream stream master. The "slave" modport is the arbiter's view (it
// consumes source beats and produces the merged stream); "master" is the
// environment's view (sources plus downstream sink).
`timescale 1ns/1ps
interface axis_rr_packet_arbiter_if #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 512
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]            s_valid;
   logic [NUM_SRC*DATA_WIDTH-1:0] s_data;
   logic [NUM_SRC-1:0]            s_last;
   logic [NUM_SRC-1:0]            s_ready;
   logic                          m_valid;
   logic [DATA_WIDTH-1:0]         m_data;
   logic                          m_last;
   logic [SRC_W-1:0]              m_src;
   logic                          m_ready;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_last, m_src
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_last, m_src
   );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin packet arbiter: shares one AXI-stream master port between
// NUM_SRC packet sources. A grant is held until the owning source ends its
// packet, or until MAX_BEATS beats have passed (forced release, flagged on
// err_overrun). Every grant is preceded by one arbitration cycle in IDLE.
//
// Build option: define AXIS_ARB_OUT_REG_EN to insert one register stage on
// m_valid/m_data/m_last/m_src. Without it the GRANT path is combinational.
`timescale 1ns/1ps
module axis_rr_packet_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 512,
   parameter int MAX_BEATS  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   axis_rr_packet_arbiter_if.slave   bus,
   output logic                      busy,
   output logic                      err_overrun
);
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int CNT_W = $clog2(MAX_BEATS);

   localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_SRC - 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [SRC_W-1:0]      grant_r;
   logic [SRC_W-1:0]      grant_s;
   logic [SRC_W-1:0]      last_grant_r;
   logic [SRC_W-1:0]      last_grant_s;
   logic [CNT_W-1:0]      beat_cnt_r;
   logic [CNT_W-1:0]      beat_cnt_s;
   logic                  err_overrun_r;
   logic                  err_overrun_s;

   logic                  sel_valid_s;
   logic                  sel_last_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic                  at_limit_s;
   logic                  take_s;

   logic [NUM_SRC-1:0]    s_ready_s;
   logic                  m_valid_s;
   logic [DATA_WIDTH-1:0] m_data_s;
   logic                  m_last_s;
   logic [SRC_W-1:0]      m_src_s;

   // First requester found searching upward from last+1, wrapping around.
   // A lone requester therefore always wins, whatever last was.
   function automatic logic [SRC_W-1:0] rr_pick(
      input logic [NUM_SRC-1:0] req,
      input logic [SRC_W-1:0]   last
   );
      logic [SRC_W-1:0] pick;
      logic             found;
      int unsigned      idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = (int'(last) + k) % NUM_SRC;
         if (!found && req[idx]) begin
            pick  = SRC_W'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   assign sel_valid_s = bus.s_valid[grant_r];
   assign sel_last_s  = bus.s_last[grant_r];
   assign sel_data_s  = bus.s_data[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];
   assign at_limit_s  = (beat_cnt_r == CNT_LIMIT);

   // Next-state, grant selection, beat counting and datapath steering.
   always_comb begin
      state_s       = state_r;
      grant_s       = grant_r;
      last_grant_s  = last_grant_r;
      beat_cnt_s    = beat_cnt_r;
      err_overrun_s = 1'b0;
      s_ready_s     = {NUM_SRC{1'b0}};
      m_valid_s     = 1'b0;
      m_data_s      = {DATA_WIDTH{1'b0}};
      m_last_s      = 1'b0;
      m_src_s       = {SRC_W{1'b0}};
      take_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|bus.s_valid) begin
               grant_s = rr_pick(bus.s_valid, last_grant_r);
               state_s = ST_GRANT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
`ifdef AXIS_ARB_OUT_REG_EN
            // Accept from the source whenever the output slot is free or draining.
            s_ready_s[grant_r] = ~m_valid_r | bus.m_ready;
            take_s             = sel_valid_s & (~m_valid_r | bus.m_ready);
`else
            s_ready_s[grant_r] = bus.m_ready;
            take_s             = sel_valid_s & bus.m_ready;
`endif
            m_valid_s = sel_valid_s;
            m_data_s  = sel_data_s;
            m_last_s  = sel_last_s | at_limit_s;
            m_src_s   = grant_r;
            if (take_s) begin
               if (sel_last_s | at_limit_s) begin
                  state_s       = ST_IDLE;
                  last_grant_s  = grant_r;
                  beat_cnt_s    = {CNT_W{1'b0}};
                  err_overrun_s = at_limit_s & ~sel_last_s;
               end else begin
                  beat_cnt_s = beat_cnt_r + CNT_ONE;
               end
            end else begin
               beat_cnt_s = beat_cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register with grant bookkeeping and the one-cycle overrun pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         grant_r       <= {SRC_W{1'b0}};
         last_grant_r  <= LAST_INIT;
         beat_cnt_r    <= {CNT_W{1'b0}};
         err_overrun_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_r       <= grant_s;
         last_grant_r  <= last_grant_s;
         beat_cnt_r    <= beat_cnt_s;
         err_overrun_r <= err_overrun_s;
      end
   end

`ifdef AXIS_ARB_OUT_REG_EN
   logic                  m_valid_r;
   logic [DATA_WIDTH-1:0] m_data_r;
   logic                  m_last_r;
   logic [SRC_W-1:0]      m_src_r;

   // Output stage: load on source acceptance, otherwise empty once the sink takes the beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid_r <= 1'b0;
         m_data_r  <= {DATA_WIDTH{1'b0}};
         m_last_r  <= 1'b0;
         m_src_r   <= {SRC_W{1'b0}};
      end else if (take_s) begin
         m_valid_r <= m_valid_s;
         m_data_r  <= m_data_s;
         m_last_r  <= m_last_s;
         m_src_r   <= m_src_s;
      end else if (bus.m_ready) begin
         m_valid_r <= 1'b0;
      end else begin
         m_valid_r <= m_valid_r;
      end
   end

   assign bus.m_valid = m_valid_r;
   assign bus.m_data  = m_data_r;
   assign bus.m_last  = m_last_r;
   assign bus.m_src   = m_src_r;
`else
   assign bus.m_valid = m_valid_s;
   assign bus.m_data  = m_data_s;
   assign bus.m_last  = m_last_s;
   assign bus.m_src   = m_src_s;
`endif

   assign bus.s_ready = s_ready_s;
   assign busy        = (state_r == ST_GRANT);
   assign err_overrun = err_overrun_r;
endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter (default combinational build).
// Sources are modelled as simple packet generators whose beat counters advance
// on each accepted beat; expected outputs are written out per cycle by hand.
`timescale 1ns/1ps
module tb_axis_rr_packet_arbiter;
   localparam int NS   = 4;
   localparam int DW   = 512;
   localparam int MAXB = 16;

   logic clk = 1'b0;
   logic reset;
   logic busy;
   logic err_overrun;

   int total = 0;
   int bad   = 0;

   int         beat_idx [NS];
   int         pkt_len  [NS];
   logic [3:0] force_last;

   axis_rr_packet_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

   axis_rr_packet_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] dv(input int src, input int n);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(src) * 32'd256 + 32'(n);
      return {16{w}};
   endfunction

   // Drive each source's data/last from its current beat number.
   task automatic apply();
      for (int i = 0; i < NS; i++) begin
         bus.s_data[i*DW +: DW] = dv(i, beat_idx[i]);
         bus.s_last[i] = force_last[i] |
                         ((pkt_len[i] > 0) && ((beat_idx[i] % pkt_len[i]) == pkt_len[i] - 1));
      end
   endtask

   // Advance one clock; sources move to their next beat if it was accepted.
   task automatic step();
      logic [3:0] fire;
      fire = bus.s_valid & bus.s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (fire[i]) beat_idx[i] = beat_idx[i] + 1;
      end
      apply();
   endtask

   task automatic cmp(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic ev, input int esrc, input int ebeat,
                      input logic elast, input logic ebusy, input logic [3:0] erdy,
                      input logic eerr);
      @(negedge clk);
      cmp({tag, ".m_valid"}, 512'(bus.m_valid), 512'(ev));
      cmp({tag, ".m_src"}, 512'(bus.m_src), 512'(esrc));
      cmp({tag, ".m_last"}, 512'(bus.m_last), 512'(elast));
      cmp({tag, ".busy"}, 512'(busy), 512'(ebusy));
      cmp({tag, ".s_ready"}, 512'(bus.s_ready), 512'(erdy));
      cmp({tag, ".err_overrun"}, 512'(err_overrun), 512'(eerr));
      if (ev) cmp({tag, ".m_data"}, bus.m_data, dv(esrc, ebeat));
      else if (!ebusy) cmp({tag, ".m_data"}, bus.m_data, 512'(0));
   endtask

   task automatic idle(input string tag, input logic eerr = 1'b0);
      chk(tag, 1'b0, 0, 0, 1'b0, 1'b0, 4'b0000, eerr);
   endtask

   task automatic gb(input string tag, input int src, input int beat, input logic last,
                     input logic [3:0] rdy);
      chk(tag, 1'b1, src, beat, last, 1'b1, rdy, 1'b0);
   endtask

   initial begin
      // Reset with every source requesting: all outputs must stay 0.
      reset = 1'b1;
      bus.s_valid = 4'b1111;
      bus.m_ready = 1'b1;
      force_last  = 4'b0000;
      for (int i = 0; i < NS; i++) begin
         beat_idx[i] = 0;
         pkt_len[i]  = 2;
      end
      apply();
      idle("rst0");
      step();
      idle("rst1");
      step();
      reset = 1'b0;

      // Test 1: sources 0 and 2, two-beat packets.
      bus.s_valid = 4'b0101;
      idle("t1_arb");
      step();
      gb("t1_s0b0", 0, 0, 1'b0, 4'b0001);
      step();
      gb("t1_s0b1", 0, 1, 1'b1, 4'b0001);
      step();
      idle("t1_bubble");
      step();
      gb("t1_s2b0", 2, 0, 1'b0, 4'b0100);
      step();
      gb("t1_s2b1", 2, 1, 1'b1, 4'b0100);
      step();
      bus.s_valid = 4'b0000;
      idle("t1_end");
      step();

      // Test 2: fresh reset, all four sources with one-beat packets.
      reset = 1'b1;
      bus.s_valid = 4'b1111;
      for (int i = 0; i < NS; i++) begin
         beat_idx[i] = 0;
         pkt_len[i]  = 1;
      end
      apply();
      idle("t2_rst");
      step();
      reset = 1'b0;
      idle("t2_arb0");
      step();
      gb("t2_g0", 0, 0, 1'b1, 4'b0001);
      step();
      idle("t2_bub0");
      step();
      gb("t2_g1", 1, 0, 1'b1, 4'b0010);
      step();
      idle("t2_bub1");
      step();
      gb("t2_g2", 2, 0, 1'b1, 4'b0100);
      step();
      idle("t2_bub2");
      step();
      gb("t2_g3", 3, 0, 1'b1, 4'b1000);
      step();
      idle("t2_bub3");
      step();
      gb("t2_g0_again", 0, 1, 1'b1, 4'b0001);
      step();
      bus.s_valid = 4'b0000;
      idle("t2_end");
      step();

      // Test 3: source 1 never asserts last; source 2 waits behind it.
      pkt_len[1]  = 0;
      pkt_len[2]  = 1;
      beat_idx[1] = 0;
      beat_idx[2] = 0;
      bus.s_valid = 4'b0110;
      apply();
      idle("t3_arb");
      step();
      for (int b = 0; b < 16; b++) begin
         gb($sformatf("t3_b%0d", b), 1, b, (b == 15), 4'b0010);
         step();
      end
      idle("t3_overrun", 1'b1);
      step();
      gb("t3_s2", 2, 0, 1'b1, 4'b0100);
      step();
      idle("t3_bub2");
      step();
      for (int b = 16; b < 20; b++) begin
         gb($sformatf("t3_b%0d", b), 1, b, 1'b0, 4'b0010);
         step();
      end
      bus.s_valid = 4'b0100;
      chk("t3_hold0", 1'b0, 1, 0, 1'b0, 1'b1, 4'b0010, 1'b0);
      step();
      chk("t3_hold1", 1'b0, 1, 0, 1'b0, 1'b1, 4'b0010, 1'b0);
      step();
      bus.s_valid   = 4'b0110;
      force_last[1] = 1'b1;
      apply();
      gb("t3_fin", 1, 20, 1'b1, 4'b0010);
      step();
      bus.s_valid = 4'b0000;
      force_last  = 4'b0000;
      apply();
      idle("t3_end");
      step();

      // Test 4: backpressure 1,0,0,1 inside a four-beat packet from source 3.
      pkt_len[3]  = 4;
      beat_idx[3] = 0;
      bus.s_valid = 4'b1000;
      apply();
      idle("t4_arb");
      step();
      gb("t4_b0", 3, 0, 1'b0, 4'b1000);
      step();
      bus.m_ready = 1'b0;
      chk("t4_stall0", 1'b1, 3, 1, 1'b0, 1'b1, 4'b0000, 1'b0);
      step();
      chk("t4_stall1", 1'b1, 3, 1, 1'b0, 1'b1, 4'b0000, 1'b0);
      step();
      bus.m_ready = 1'b1;
      gb("t4_b1", 3, 1, 1'b0, 4'b1000);
      step();
      gb("t4_b2", 3, 2, 1'b0, 4'b1000);
      step();
      gb("t4_b3", 3, 3, 1'b1, 4'b1000);
      step();
      bus.s_valid = 4'b0000;
      idle("t4_end");
      step();

      // Test 5: lone source 0 re-wins, then reset lands during beat 3 of 5.
      pkt_len[0]  = 1;
      beat_idx[0] = 0;
      bus.s_valid = 4'b0001;
      apply();
      idle("t5_arb0");
      step();
      gb("t5_short", 0, 0, 1'b1, 4'b0001);
      step();
      pkt_len[0]  = 5;
      beat_idx[0] = 0;
      apply();
      idle("t5_bub");
      step();
      gb("t5_b0", 0, 0, 1'b0, 4'b0001);
      step();
      gb("t5_b1", 0, 1, 1'b0, 4'b0001);
      step();
      gb("t5_b2", 0, 2, 1'b0, 4'b0001);
      #1;
      reset = 1'b1;
      #1;
      cmp("t5_async.m_valid", 512'(bus.m_valid), 512'(0));
      cmp("t5_async.m_data", bus.m_data, 512'(0));
      cmp("t5_async.m_last", 512'(bus.m_last), 512'(0));
      cmp("t5_async.m_src", 512'(bus.m_src), 512'(0));
      cmp("t5_async.s_ready", 512'(bus.s_ready), 512'(0));
      cmp("t5_async.busy", 512'(busy), 512'(0));
      cmp("t5_async.err_overrun", 512'(err_overrun), 512'(0));
      step();
      bus.s_valid = 4'b0011;
      pkt_len[0]  = 1;
      pkt_len[1]  = 1;
      beat_idx[0] = 0;
      beat_idx[1] = 0;
      apply();
      idle("t5_inreset");
      step();
      reset = 1'b0;
      idle("t5_arb1");
      step();
      gb("t5_src0_first", 0, 0, 1'b1, 4'b0001);
      step();
      idle("t5_bub1");
      step();
      gb("t5_src1", 1, 0, 1'b1, 4'b0010);
      step();
      bus.s_valid = 4'b0000;
      idle("t5_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
